idli_encode_m: RTL and testbench
================================

IDLI_ENCODE_M -- requirements
Module: idli_encode_m

Interface
REQ-001 The module SHALL have port i_enc_gck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port i_enc_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port i_enc_data, input, 16 bits: the instruction word to serialise.
REQ-004 The module SHALL have port i_enc_data_vld, input, 1 bit: i_enc_data is valid this cycle.
REQ-005 The module SHALL have port o_enc_data_rdy, output, 1 bit: the module accepts i_enc_data this cycle.
REQ-006 The module SHALL have port o_enc_nib, output, 4 bits: the current nibble for the downstream decoder's nibble input.
REQ-007 The module SHALL have port o_enc_nib_vld, output, 1 bit: o_enc_nib is valid; drives the decoder's nibble-valid input.
REQ-008 The module SHALL have port o_enc_nib_last, output, 1 bit: the current nibble is nibble 3 of its word.
REQ-009 The module SHALL have port i_enc_stall, input, 1 bit: the consumer does not take the current nibble this cycle.

Function
REQ-010 A word SHALL be accepted on any rising edge where i_enc_data_vld and o_enc_data_rdy are both 1.
REQ-011 Nibble order SHALL be data[3:0], data[7:4], data[11:8], data[15:12], so that opcode class bits [1:0] appear first.
REQ-012 Nibble 0 of an accepted word SHALL appear on o_enc_nib, with o_enc_nib_vld=1, in the cycle after acceptance (latency 1).
REQ-013 The state machine SHALL have states IDLE, N0, N1, N2, N3; a 2-bit nibble counter with a busy flag is an acceptable encoding.
REQ-014 The module SHALL advance N0->N1->N2->N3 only on cycles where o_enc_nib_vld=1 and i_enc_stall=0; while i_enc_stall=1, o_enc_nib, o_enc_nib_vld and o_enc_nib_last SHALL hold.
REQ-015 On leaving N3, the module SHALL go to N0 if a next word is available that cycle, else to IDLE; back-to-back words SHALL produce contiguous nibbles with no bubble.
REQ-016 o_enc_nib_last SHALL be 1 exactly in state N3.
REQ-017 In IDLE, o_enc_nib_vld SHALL be 0 and o_enc_nib SHALL be 4'h0.
REQ-018 i_enc_stall SHALL be ignored while in IDLE.
REQ-019 i_enc_data SHALL be captured into an internal 16-bit register at acceptance; later changes on i_enc_data SHALL NOT affect the word in flight.

Reset
REQ-020 During reset, the state SHALL be IDLE, o_enc_nib_vld=0, o_enc_nib=4'h0, o_enc_nib_last=0, and the skid buffer (if present) SHALL be empty.
REQ-021 Reset asserted mid-word SHALL drop o_enc_nib_vld immediately (asynchronously) and discard the word in flight and any buffered word.
REQ-022 o_enc_data_rdy SHALL be 1 in the first cycle after reset release.

Configuration
REQ-023 The module SHALL support macro IDLI_ENC_SKID_EN.
REQ-024 With IDLI_ENC_SKID_EN undefined, o_enc_data_rdy SHALL equal (state==IDLE) | (state==N3 & ~i_enc_stall), which is a combinational path from i_enc_stall.
REQ-025 With IDLI_ENC_SKID_EN defined, a one-entry skid buffer SHALL be present and o_enc_data_rdy SHALL equal ~skid_full, a pure register output with no path from i_enc_stall.
REQ-026 With IDLI_ENC_SKID_EN defined, a word accepted while not IDLE SHALL enter the skid buffer and be loaded into the shift register on the N3 exit.
REQ-027 With IDLI_ENC_SKID_EN defined, nibble order and timing SHALL be identical to the undefined case for a single word.

Structure
REQ-028 Package idli_pkg SHALL hold the nibble type (4-bit), the instruction word type (16-bit), the encoder state_t enum, and the constant ENC_NIBS=4.
REQ-029 The skid buffer SHALL be the sub-module idli_enc_skid_m, instantiated only under IDLI_ENC_SKID_EN.

Verification
REQ-030 Single word: accept 16'hA5C3, no stall -> o_enc_nib = 3,C,5,A on cycles +1..+4, o_enc_nib_last=1 only on cycle +4, then IDLE with o_enc_nib_vld=0.
REQ-031 Stall: 16'hA5C3 with i_enc_stall=1 for 2 cycles while nibble C is shown -> C held 3 cycles, then 5, A; total 6 valid cycles.
REQ-032 Back-to-back: 16'h1234 then 16'h5678 offered continuously -> 8 contiguous valid nibbles 4,3,2,1,8,7,6,5 with no bubble.
REQ-033 Reset mid-word: assert i_enc_rst_n=0 while nibble 2 is shown -> o_enc_nib_vld=0 at once; after release, o_enc_data_rdy=1 and the next word starts at nibble 0.
REQ-034 Skid (IDLI_ENC_SKID_EN defined): offer 16'hBEEF while 16'h0F0F is stalled in N1 -> BEEF accepted, o_enc_data_rdy=0 until the buffer drains, then nibbles F,E,E,B follow F,0,F,0.
REQ-035 Comb path (IDLI_ENC_SKID_EN undefined): in N3 toggle i_enc_stall -> o_enc_data_rdy follows ~i_enc_stall in the same cycle.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and helpers for the IDLI instruction-word nibble encoder.
// The package is imported by the encoder top and by its skid-buffer sub-module.
package idli_pkg;

  localparam int ENC_NIBS = 4;
  localparam int NIB_W    = 4;
  localparam int WORD_W   = NIB_W * ENC_NIBS;

  typedef logic [NIB_W-1:0]  nib_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [1:0]        nib_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_N0   = 3'd1,
    ST_N1   = 3'd2,
    ST_N2   = 3'd3,
    ST_N3   = 3'd4
  } state_t;

  // Nibble position presented while in a given state; IDLE maps to 0 and is masked by the caller.
  function automatic nib_idx_t state_idx(input state_t s);
    nib_idx_t idx;
    idx = 2'd0;
    case (s)
      ST_N1:   idx = 2'd1;
      ST_N2:   idx = 2'd2;
      ST_N3:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic state_t state_adv(input state_t s);
    state_t nxt;
    nxt = s;
    case (s)
      ST_N0:   nxt = ST_N1;
      ST_N1:   nxt = ST_N2;
      ST_N2:   nxt = ST_N3;
      default: nxt = s;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/idli_enc_skid_m.sv
// One-entry skid buffer holding a single instruction word for the encoder.
// Push and pop are never asserted together by the encoder; push takes priority if they are.
import idli_pkg::*;

module idli_enc_skid_m (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  word_t i_push_data,
  input  logic  i_pop,
  output logic  o_full,
  output word_t o_data
);

  logic  full_q, full_d;
  word_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (i_pop) begin
      full_d = 1'b0;
    end
    if (i_push) begin
      full_d = 1'b1;
      data_d = i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_full = full_q;
  assign o_data = data_q;

endmodule

// File: rtl/idli_encode_m.sv
// Serialises 16-bit instruction words into four nibbles, low nibble first.
// Optional macro IDLI_ENC_SKID_EN adds a one-entry skid buffer so ready is a pure register output.
import idli_pkg::*;

module idli_encode_m (
  input  logic        i_enc_gck,
  input  logic        i_enc_rst_n,
  input  logic [15:0] i_enc_data,
  input  logic        i_enc_data_vld,
  output logic        o_enc_data_rdy,
  output logic [3:0]  o_enc_nib,
  output logic        o_enc_nib_vld,
  output logic        o_enc_nib_last,
  input  logic        i_enc_stall
);

  state_t state_q, state_d;
  word_t  word_q, word_d;

  logic   nib_vld;
  logic   advance;
  logic   n3_exit;
  logic   accept;
  logic   next_avail;
  word_t  next_word;
  nib_t   nib_arr [ENC_NIBS];

  genvar gi;
  generate
    for (gi = 0; gi < ENC_NIBS; gi++) begin : g_nib
      assign nib_arr[gi] = word_q[gi*NIB_W +: NIB_W];
    end
  endgenerate

  always_comb begin
    nib_vld = (state_q != ST_IDLE);
    advance = nib_vld & ~i_enc_stall;
    n3_exit = (state_q == ST_N3) & advance;
  end

`ifdef IDLI_ENC_SKID_EN
  logic  skid_full;
  logic  skid_push;
  logic  skid_pop;
  word_t skid_data;

  idli_enc_skid_m u_skid (
    .clk         (i_enc_gck),
    .rst_n       (i_enc_rst_n),
    .i_push      (skid_push),
    .i_push_data (i_enc_data),
    .i_pop       (skid_pop),
    .o_full      (skid_full),
    .o_data      (skid_data)
  );

  // A word arriving exactly on the N3 exit with the buffer empty bypasses it so the stream stays contiguous.
  always_comb begin
    o_enc_data_rdy = ~skid_full;
    accept         = i_enc_data_vld & ~skid_full;
    skid_push      = accept & (state_q != ST_IDLE) & ~n3_exit;
    skid_pop       = n3_exit & skid_full;
    next_avail     = skid_full | accept;
    next_word      = skid_full ? skid_data : i_enc_data;
  end
`else
  always_comb begin
    o_enc_data_rdy = (state_q == ST_IDLE) | ((state_q == ST_N3) & ~i_enc_stall);
    accept         = i_enc_data_vld & o_enc_data_rdy;
    next_avail     = accept;
    next_word      = i_enc_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (next_avail) begin
          state_d = ST_N0;
          word_d  = next_word;
        end
      end
      ST_N0, ST_N1, ST_N2: begin
        if (advance) begin
          state_d = state_adv(state_q);
        end
      end
      ST_N3: begin
        if (advance) begin
          if (next_avail) begin
            state_d = ST_N0;
            word_d  = next_word;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_enc_gck or negedge i_enc_rst_n) begin
    if (!i_enc_rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them without waiting for a clock.
  always_comb begin
    o_enc_nib_vld  = nib_vld;
    o_enc_nib_last = (state_q == ST_N3);
    o_enc_nib      = nib_vld ? nib_arr[state_idx(state_q)] : 4'h0;
  end

endmodule

// File: tb/tb_idli_encode_m.sv
// Directed, table-driven bench for idli_encode_m; covers both builds of IDLI_ENC_SKID_EN.
`timescale 1ns/1ps

module tb_idli_encode_m;

`ifdef IDLI_ENC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        data_vld;
  logic        data_rdy;
  logic [3:0]  nib;
  logic        nib_vld;
  logic        nib_last;
  logic        stall;

  int total;
  int bad;

  idli_encode_m dut (
    .i_enc_gck      (clk),
    .i_enc_rst_n    (rst_n),
    .i_enc_data     (data),
    .i_enc_data_vld (data_vld),
    .o_enc_data_rdy (data_rdy),
    .o_enc_nib      (nib),
    .o_enc_nib_vld  (nib_vld),
    .o_enc_nib_last (nib_last),
    .i_enc_stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        vld;
    logic        stall;
    logic        rdy;
    logic        rdy_skid;
    logic        nv;
    logic [3:0]  nib;
    logic        last;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic [15:0] d, input logic v, input logic s,
                              input logic r, input logic rs, input logic nv,
                              input logic [3:0] n, input logic l);
    vec_t x;
    x.data = d; x.vld = v; x.stall = s; x.rdy = r; x.rdy_skid = rs;
    x.nv = nv; x.nib = n; x.last = l;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] n, input logic l);
    chk({tag, ".vld"},  {15'd0, nib_vld},  {15'd0, v});
    chk({tag, ".nib"},  {12'd0, nib},      {12'd0, n});
    chk({tag, ".last"}, {15'd0, nib_last}, {15'd0, l});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // single word, stall on nibble C, stall ignored in IDLE, back-to-back words
    tbl[0]  = mk(16'hA5C3, 1, 0, 1, 1, 0, 4'h0, 0);
    tbl[1]  = mk(16'hA5C3, 0, 0, 0, 1, 1, 4'h3, 0);
    tbl[2]  = mk(16'h0000, 0, 0, 0, 1, 1, 4'hC, 0);
    tbl[3]  = mk(16'h0000, 0, 0, 0, 1, 1, 4'h5, 0);
    tbl[4]  = mk(16'h0000, 0, 0, 1, 1, 1, 4'hA, 1);
    tbl[5]  = mk(16'h0000, 0, 0, 1, 1, 0, 4'h0, 0);
    tbl[6]  = mk(16'hA5C3, 1, 0, 1, 1, 0, 4'h0, 0);
    tbl[7]  = mk(16'hA5C3, 0, 0, 0, 1, 1, 4'h3, 0);
    tbl[8]  = mk(16'h0000, 0, 1, 0, 1, 1, 4'hC, 0);
    tbl[9]  = mk(16'h0000, 0, 1, 0, 1, 1, 4'hC, 0);
    tbl[10] = mk(16'h0000, 0, 0, 0, 1, 1, 4'hC, 0);
    tbl[11] = mk(16'h0000, 0, 0, 0, 1, 1, 4'h5, 0);
    tbl[12] = mk(16'h0000, 0, 0, 1, 1, 1, 4'hA, 1);
    tbl[13] = mk(16'h1234, 1, 1, 1, 1, 0, 4'h0, 0);
    tbl[14] = mk(16'h5678, 1, 0, 0, 1, 1, 4'h4, 0);
    tbl[15] = mk(16'h5678, 1, 0, 0, 0, 1, 4'h3, 0);
    tbl[16] = mk(16'h5678, 1, 0, 0, 0, 1, 4'h2, 0);
    tbl[17] = mk(16'h5678, 1, 0, 1, 0, 1, 4'h1, 1);
    tbl[18] = mk(16'h0000, 0, 0, 0, 1, 1, 4'h8, 0);
    tbl[19] = mk(16'h0000, 0, 0, 0, 1, 1, 4'h7, 0);
    tbl[20] = mk(16'h0000, 0, 0, 0, 1, 1, 4'h6, 0);
    tbl[21] = mk(16'h0000, 0, 0, 1, 1, 1, 4'h5, 1);
    tbl[22] = mk(16'h0000, 0, 0, 1, 1, 0, 4'h0, 0);

    rst_n    = 1'b0;
    data     = 16'h0;
    data_vld = 1'b0;
    stall    = 1'b0;

    #3;
    chk_out("reset", 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_reset.rdy", {15'd0, data_rdy}, 16'd1);
    tick();

    for (int i = 0; i < 23; i++) begin
      data     = tbl[i].data;
      data_vld = tbl[i].vld;
      stall    = tbl[i].stall;
      #1;
      $display("row %0d data=%h vld=%b stall=%b -> rdy=%b nv=%b nib=%h last=%b",
               i, data, data_vld, stall, data_rdy, nib_vld, nib, nib_last);
      chk($sformatf("row%0d.rdy", i), {15'd0, data_rdy},
          {15'd0, (SKID ? tbl[i].rdy_skid : tbl[i].rdy)});
      chk_out($sformatf("row%0d", i), tbl[i].nv, tbl[i].nib, tbl[i].last);
      tick();
    end

    // reset asserted while nibble index 2 is on the bus
    data = 16'h4321; data_vld = 1'b1; stall = 1'b0;
    tick();
    data_vld = 1'b0;
    #1; chk_out("rst_seq.n0", 1'b1, 4'h1, 1'b0);
    tick();
    #1; chk_out("rst_seq.n1", 1'b1, 4'h2, 1'b0);
    tick();
    #1; chk_out("rst_seq.n2", 1'b1, 4'h3, 1'b0);
    rst_n = 1'b0;
    #1; chk_out("rst_seq.async", 1'b0, 4'h0, 1'b0);
    tick();
    #1; rst_n = 1'b1;
    #1; chk("rst_seq.rdy", {15'd0, data_rdy}, 16'd1);
    chk_out("rst_seq.idle", 1'b0, 4'h0, 1'b0);
    data = 16'h00C7; data_vld = 1'b1;
    $display("rst_seq: offer %h after reset release", data);
    tick();
    data_vld = 1'b0; data = 16'hFFFF;
    #1; chk_out("rst_seq.w0", 1'b1, 4'h7, 1'b0);
    tick();
    #1; chk_out("rst_seq.w1", 1'b1, 4'hC, 1'b0);
    tick();
    #1; chk_out("rst_seq.w2", 1'b1, 4'h0, 1'b0);
    tick();
    #1; chk_out("rst_seq.w3", 1'b1, 4'h0, 1'b1);
    tick();
    #1; chk_out("rst_seq.done", 1'b0, 4'h0, 1'b0);

    // toggle stall within one N3 cycle: ready follows ~stall only without the skid buffer
    tick();
    data = 16'h9ABC; data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    #1; chk("comb.rdy_s1", {15'd0, data_rdy}, {15'd0, (SKID ? 1'b1 : 1'b0)});
    chk_out("comb.n3", 1'b1, 4'h9, 1'b1);
    stall = 1'b0;
    #1; chk("comb.rdy_s0", {15'd0, data_rdy}, 16'd1);
    stall = 1'b1;
    #1; chk("comb.rdy_s1b", {15'd0, data_rdy}, {15'd0, (SKID ? 1'b1 : 1'b0)});
    $display("comb: N3 stall toggled, rdy=%b", data_rdy);
    stall = 1'b0;
    tick();
    #1; chk_out("comb.idle", 1'b0, 4'h0, 1'b0);

`ifdef IDLI_ENC_SKID_EN
    // BEEF offered while 0F0F is stalled in N1
    tick();
    data = 16'h0F0F; data_vld = 1'b1;
    #1; chk("skid.rdy0", {15'd0, data_rdy}, 16'd1);
    tick();
    data_vld = 1'b0;
    #1; chk_out("skid.a0", 1'b1, 4'hF, 1'b0);
    tick();
    stall = 1'b1; data = 16'hBEEF; data_vld = 1'b1;
    #1; chk("skid.rdy_offer", {15'd0, data_rdy}, 16'd1);
    chk_out("skid.a1", 1'b1, 4'h0, 1'b0);
    $display("skid: offer %h during stall", data);
    tick();
    data_vld = 1'b0; data = 16'h0000;
    #1; chk("skid.rdy_full", {15'd0, data_rdy}, 16'd0);
    chk_out("skid.a1_hold", 1'b1, 4'h0, 1'b0);
    tick();
    stall = 1'b0;
    #1; chk("skid.rdy_full2", {15'd0, data_rdy}, 16'd0);
    chk_out("skid.a1_rel", 1'b1, 4'h0, 1'b0);
    tick();
    #1; chk_out("skid.a2", 1'b1, 4'hF, 1'b0);
    tick();
    #1; chk_out("skid.a3", 1'b1, 4'h0, 1'b1);
    chk("skid.rdy_n3", {15'd0, data_rdy}, 16'd0);
    tick();
    #1; chk_out("skid.b0", 1'b1, 4'hF, 1'b0);
    chk("skid.rdy_drained", {15'd0, data_rdy}, 16'd1);
    tick();
    #1; chk_out("skid.b1", 1'b1, 4'hE, 1'b0);
    tick();
    #1; chk_out("skid.b2", 1'b1, 4'hE, 1'b0);
    tick();
    #1; chk_out("skid.b3", 1'b1, 4'hB, 1'b1);
    tick();
    #1; chk_out("skid.idle", 1'b0, 4'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
